// File: rtl/bpf_defs_pkg.sv
// Shared definitions for the packet snooper and its bpfvm neighbour.
// Holds the snooper state encoding and the tkeep-to-byte-count helper.
package bpf_defs_pkg;

    localparam int PACKET_ADDR_WIDTH_DEF = 10;

    typedef enum logic [2:0] {
        WAIT_BUF,
        CAPTURE,
        DRAIN,
        DONE,
        GUARD
    } snoop_state_e;

    // Bytes carried by a final beat; an all-zero keep means a full word.
    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        logic [2:0] n;
        n = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
        if (n == 3'd0) begin
            n = 3'd4;
        end
        return n;
    endfunction

endpackage

// File: rtl/packet_snooper.sv
// Captures one AXI-stream packet into the bpfvm packet memory and hands
// the filled buffer over with a one-cycle done pulse.
module packet_snooper
    import bpf_defs_pkg::*;
#(
    parameter int PACKET_ADDR_WIDTH = PACKET_ADDR_WIDTH_DEF,
    parameter int PACKET_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  s_axis_tdata,
    input  logic [3:0]                   s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [PACKET_ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [PACKET_DATA_WIDTH-1:0] snooper_wr_data,
    output logic                         snooper_wr_en,
    output logic                         snooper_done,
    input  logic                         ready_for_snooper,
    output logic [PACKET_ADDR_WIDTH+2:0] byte_len,
    output logic [31:0]                  pkt_count,
    output logic [15:0]                  trunc_count
);

    localparam int AW = PACKET_ADDR_WIDTH;
    localparam int BW = PACKET_ADDR_WIDTH + 3;
    localparam logic [AW-1:0] IDX_MAX = {AW{1'b1}};
    localparam logic [BW-1:0] TRUNC_LEN = BW'(4) << AW;

    snoop_state_e state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [BW-1:0] byte_len_q, byte_len_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] trunc_count_q, trunc_count_d;
    logic truncated_q, truncated_d;
    logic tready_q, tready_d;
    logic wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [PACKET_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic done_q, done_d;

    logic accept;
    logic [BW-1:0] last_len;

    assign accept = s_axis_tvalid & tready_q;
    assign last_len = {1'b0, idx_q, 2'b00} + BW'(keep_bytes(s_axis_tkeep));

    // Next-state, write-port and counter logic for the capture FSM.
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        byte_len_d = byte_len_q;
        pkt_count_d = pkt_count_q;
        trunc_count_d = trunc_count_q;
        truncated_d = truncated_q;
        wr_en_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d = 1'b0;
        unique case (state_q)
            WAIT_BUF: begin
                if (ready_for_snooper) begin
                    state_d = CAPTURE;
                    idx_d = '0;
                    truncated_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    wr_en_d = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = PACKET_DATA_WIDTH'(s_axis_tdata);
                    idx_d = idx_q + AW'(1);
                    if (s_axis_tlast) begin
                        byte_len_d = last_len;
                        state_d = DONE;
                    end else if (idx_q == IDX_MAX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis_tlast) begin
                    truncated_d = 1'b1;
                    byte_len_d = TRUNC_LEN;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d = 1'b1;
                pkt_count_d = pkt_count_q + 32'd1;
                if (truncated_q && (trunc_count_q != 16'hFFFF)) begin
                    trunc_count_d = trunc_count_q + 16'd1;
                end
                state_d = GUARD;
            end
            GUARD: begin
                state_d = WAIT_BUF;
            end
            default: begin
                state_d = WAIT_BUF;
            end
        endcase
        tready_d = (state_d == CAPTURE) || (state_d == DRAIN);
    end

    // State and registered outputs; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT_BUF;
            idx_q <= '0;
            byte_len_q <= '0;
            pkt_count_q <= '0;
            trunc_count_q <= '0;
            truncated_q <= 1'b0;
            tready_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            byte_len_q <= byte_len_d;
            pkt_count_q <= pkt_count_d;
            trunc_count_q <= trunc_count_d;
            truncated_q <= truncated_d;
            tready_q <= tready_d;
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q <= done_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign snooper_wr_addr = wr_addr_q;
    assign snooper_wr_data = wr_data_q;
    assign snooper_wr_en = wr_en_q;
    assign snooper_done = done_q;
    assign byte_len = byte_len_q;
    assign pkt_count = pkt_count_q;
    assign trunc_count = trunc_count_q;

endmodule

// File: tb/tb_packet_snooper.sv
// Directed and randomized bench for packet_snooper with a scoreboard of
// expected memory writes and done pulses derived from packet lengths.
module tb_packet_snooper;

    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0] s_axis_tkeep = '0;
    logic s_axis_tvalid = 1'b0;
    logic s_axis_tlast = 1'b0;
    logic s_axis_tready;
    logic [AW-1:0] snooper_wr_addr;
    logic [31:0] snooper_wr_data;
    logic snooper_wr_en;
    logic snooper_done;
    logic ready_for_snooper = 1'b1;
    logic [AW+2:0] byte_len;
    logic [31:0] pkt_count;
    logic [15:0] trunc_count;

    packet_snooper #(.PACKET_ADDR_WIDTH(AW), .PACKET_DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .snooper_wr_addr(snooper_wr_addr),
        .snooper_wr_data(snooper_wr_data),
        .snooper_wr_en(snooper_wr_en),
        .snooper_done(snooper_done),
        .ready_for_snooper(ready_for_snooper),
        .byte_len(byte_len),
        .pkt_count(pkt_count),
        .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr = 0;
    logic [63:0] wr_q[$];
    logic [63:0] exp_wr[$];
    int done_q[$];
    int exp_done[$];
    int lat_q[$];
    int exp_lat[$];
    int pkt_m = 0;
    int trunc_m = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (snooper_wr_en) begin
            wr_q.push_back(64'({snooper_wr_addr, snooper_wr_data}));
            last_wr = cyc;
        end
        if (snooper_done) begin
            done_q.push_back(int'(byte_len));
            lat_q.push_back(cyc - last_wr);
        end
    end

    always @(negedge clk) begin
        if (rand_ready) ready_for_snooper = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_len(input int n, input logic [3:0] k);
        if (n > DEPTH) return 4 * DEPTH;
        return 4 * (n - 1) + ((k == 4'd0) ? 4 : $countones(k));
    endfunction

    // Drives one packet; caller is at a negedge. Returns stall count.
    task automatic send_pkt(input int n, input logic [3:0] k,
                            input bit gaps, input bit hold,
                            input bit nolast, output int stalls);
        logic [31:0] w[$];
        int i;
        int t;
        bit v;
        stalls = 0;
        i = 0;
        t = 0;
        for (int j = 0; j < n; j++) begin
            w.push_back($urandom);
            if (j < DEPTH) exp_wr.push_back(64'({AW'(j), w[j]}));
        end
        while (i < n) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tvalid = v;
            s_axis_tdata = w[i];
            s_axis_tlast = (i == n - 1) && !nolast;
            s_axis_tkeep = (i == n - 1) ? k : 4'($urandom);
            if (v && !s_axis_tready) stalls++;
            if (v && s_axis_tready) i++;
            @(negedge clk);
            t++;
            if (t > 4 * n + 200) begin
                chk("send_timeout", 64'(i), 64'(n));
                break;
            end
        end
        if (!hold) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast = 1'b0;
        end
        if (!nolast) begin
            exp_done.push_back(exp_len(n, k));
            exp_lat.push_back((n > DEPTH) ? 0 : 1);
            pkt_m++;
            if (n > DEPTH && trunc_m < 65535) trunc_m++;
        end
    endtask

    task automatic compare(input string tag);
        int t;
        int bad;
        t = 0;
        while (done_q.size() < exp_done.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
            if (wr_q[i] !== exp_wr[i]) bad++;
        end
        chk({tag, "_wr_content"}, 64'(bad), 64'd0);
        chk({tag, "_done_count"}, 64'(done_q.size()), 64'(exp_done.size()));
        for (int i = 0; i < done_q.size() && i < exp_done.size(); i++) begin
            chk({tag, "_byte_len"}, 64'(done_q[i]), 64'(exp_done[i]));
            if (exp_lat[i] != 0)
                chk({tag, "_done_lat"}, 64'(lat_q[i]), 64'(exp_lat[i]));
        end
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(pkt_m));
        chk({tag, "_trunc_count"}, 64'(trunc_count), 64'(trunc_m));
        wr_q.delete();
        exp_wr.delete();
        done_q.delete();
        exp_done.delete();
        lat_q.delete();
        exp_lat.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
        chk({tag, "_wr_en"}, 64'(snooper_wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(snooper_wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(snooper_wr_data), 64'd0);
        chk({tag, "_done"}, 64'(snooper_done), 64'd0);
        chk({tag, "_byte_len"}, 64'(byte_len), 64'd0);
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
        chk({tag, "_trunc_count"}, 64'(trunc_count), 64'd0);
    endtask

    initial begin
        int st;
        int busy;
        int n;
        logic [3:0] k;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        send_pkt(14, 4'hF, 1'b0, 1'b0, 1'b0, st);
        compare("pkt14");

        send_pkt(11, 4'b1100, 1'b0, 1'b0, 1'b0, st);
        ready_for_snooper = 1'b0;
        compare("pkt11");

        busy = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'h70b31760;
        s_axis_tkeep = 4'hF;
        repeat (30) begin
            if (s_axis_tready || snooper_wr_en) busy++;
            @(negedge clk);
        end
        chk("noready_activity", 64'(busy), 64'd0);
        ready_for_snooper = 1'b1;
        send_pkt(5, 4'b1000, 1'b0, 1'b0, 1'b0, st);
        chk("ready_latency", 64'(st), 64'd1);
        compare("late_ready");

        send_pkt(1030, 4'hF, 1'b0, 1'b0, 1'b0, st);
        compare("trunc1030");

        send_pkt(5, 4'hF, 1'b0, 1'b0, 1'b1, st);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b1;
        pkt_m = 0;
        trunc_m = 0;
        compare("abandoned");
        send_pkt(3, 4'hF, 1'b0, 1'b0, 1'b0, st);
        compare("after_reset");

        send_pkt(7, 4'b1110, 1'b0, 1'b1, 1'b0, st);
        send_pkt(9, 4'b0000, 1'b0, 1'b0, 1'b0, st);
        chk("b2b_stalls", 64'(st), 64'd3);
        compare("b2b");

        rand_ready = 1'b1;
        for (int p = 0; p < 12; p++) begin
            n = $urandom_range(1, 40);
            k = 4'($urandom_range(0, 4));
            case (k)
                4'd1: k = 4'b1000;
                4'd2: k = 4'b1100;
                4'd3: k = 4'b1110;
                4'd4: k = 4'b1111;
                default: k = 4'b0000;
            endcase
            send_pkt(n, k, 1'b1, 1'b0, 1'b0, st);
        end
        rand_ready = 1'b0;
        ready_for_snooper = 1'b1;
        compare("random");

        send_pkt(DEPTH, 4'b1110, 1'b0, 1'b0, 1'b0, st);
        compare("full1024");
        send_pkt(DEPTH + 1, 4'b1000, 1'b1, 1'b0, 1'b0, st);
        compare("trunc1025");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_snooper.md
PACKET_SNOOPER -- requirements
Module: packet_snooper

Interface
REQ-001 Parameter PACKET_ADDR_WIDTH, default 10, packet-memory word-address width.
REQ-002 Parameter PACKET_DATA_WIDTH, default 32, packet-memory write width, fixed at 32.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 s_axis_tdata  input  32  ingress packet word, first byte in bits [31:24].
REQ-006 s_axis_tkeep  input  4  byte enables; contiguous from bit 3; only meaningful on the last beat.
REQ-007 s_axis_tvalid  input  1  ingress beat valid.
REQ-008 s_axis_tlast  input  1  last beat of the packet.
REQ-009 s_axis_tready  output  1  ingress beat accepted when both tvalid and tready are high.
REQ-010 snooper_wr_addr  output  PACKET_ADDR_WIDTH  packet-memory word address.
REQ-011 snooper_wr_data  output  32  packet-memory write data.
REQ-012 snooper_wr_en  output  1  packet-memory write strobe.
REQ-013 snooper_done  output  1  one-cycle pulse that hands the filled buffer to the bpfvm.
REQ-014 ready_for_snooper  input  1  bpfvm has a free buffer.
REQ-015 byte_len  output  PACKET_ADDR_WIDTH+3  captured length in bytes; valid while snooper_done is high.
REQ-016 pkt_count  output  32  count of packets handed off; wraps.
REQ-017 trunc_count  output  16  count of truncated packets; saturates at 16'hFFFF.

Function
REQ-018 The block SHALL use the states WAIT_BUF, CAPTURE, DRAIN, DONE and GUARD.
REQ-019 WAIT_BUF: tready=0; go to CAPTURE on the cycle after ready_for_snooper is sampled high.
REQ-020 CAPTURE: tready=1; each accepted beat produces wr_en=1, wr_data=tdata and wr_addr=word index on the next cycle (registered, 1-cycle latency); the first word goes to address 0.
REQ-021 On an accepted beat with tlast in CAPTURE: go to DONE.
REQ-022 If the accepted word index equals 2^PACKET_ADDR_WIDTH-1 without tlast: write that word, then go to DRAIN.
REQ-023 DRAIN: tready=1; no writes; beats are discarded; on tlast, set the truncated flag and go to DONE.
REQ-024 DONE: snooper_done=1 for exactly one cycle, one cycle after the last wr_en; byte_len is valid in the same cycle; pkt_count increments; trunc_count increments if truncated (saturating); then go to GUARD.
REQ-025 GUARD: one cycle with tready=0 and ready_for_snooper ignored, so the bpfvm can drop it; then go to WAIT_BUF.
REQ-026 byte_len = 4*(words_written-1) + number of ones in tkeep of the last written beat.
REQ-027 When truncated, byte_len SHALL be 4*2^PACKET_ADDR_WIDTH.
REQ-028 tkeep is ignored on all beats other than the last.
REQ-029 A tkeep of 0 on the last beat SHALL count as 4 bytes.
REQ-030 A single-beat packet (tlast on the first beat) is legal.
REQ-031 Changes on ready_for_snooper during CAPTURE or DRAIN SHALL have no effect.
REQ-032 While tready=1 and tvalid=0, the block SHALL hold its state and word index.

Reset
REQ-033 While rst=0 at a clk edge, the block SHALL enter WAIT_BUF and clear the word index, byte_len, pkt_count, trunc_count, the truncated flag, tready, wr_en, wr_addr, wr_data and snooper_done.
REQ-034 A reset that arrives mid-packet SHALL abandon the packet with no snooper_done pulse; the next packet starts at address 0.

Structure
REQ-035 The shared package bpf_defs_pkg SHALL hold the snooper state enum, the PACKET_ADDR_WIDTH default and a keep-to-byte-count function.
REQ-036 No sub-module; a single always_ff FSM/datapath plus combinational next-state logic.

Verification
REQ-037 14-word packet (70b31760..0000FFFF), tkeep=F, ready high -> writes to addresses 0..13, done one cycle after the address-13 write, byte_len=56, pkt_count=1.
REQ-038 ready_for_snooper low for 30 cycles with tvalid high -> tready=0 and no wr_en; raise ready -> capture begins 1 cycle later at address 0.
REQ-039 11-word packet, last tkeep=4'b1100 -> byte_len=42, exactly 11 writes.
REQ-040 1030-word packet, PACKET_ADDR_WIDTH=10 -> 1024 writes, 6 beats drained, byte_len=4096, trunc_count=1, a single done pulse.
REQ-041 rst=0 for 1 cycle after 5 accepted words -> no done, all outputs 0; the following 3-word packet writes addresses 0..2 and then pulses done.
REQ-042 Two back-to-back packets with continuous tvalid -> tready=0 during DONE/GUARD/WAIT_BUF, the second packet starts at address 0, pkt_count=2.
